// File: rtl/rtc_seq_pkg.sv
// rtl/rtc_seq_pkg.sv - shared types and constants for the RTC bus sequencer
package rtc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_SETUP,
        ST_ADDR_STROBE,
        ST_ADDR_HOLD,
        ST_DATA_SETUP,
        ST_DATA_STROBE,
        ST_DATA_HOLD,
        ST_DONE
    } state_e;

    localparam int          IDX_W    = 4;
    localparam logic [7:0]  BUS_IDLE = 8'h00;

endpackage

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - loadable down-counter; last is high on the final cycle of a bus phase
module rtc_phase_timer #(
    parameter int T_PHASE = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    localparam int         W        = $clog2(T_PHASE + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(T_PHASE - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - RTC multiplexed-bus sequencer: pending write vs periodic read bursts
// Optional: RTC_XFER_CMD_EN prefixes each burst with a transfer-command write to CMD_ADDR.
module rtc_bus_sequencer
    import rtc_seq_pkg::*;
#(
    parameter int         T_PHASE     = 10,
    parameter int         READ_PERIOD = 100000,
    parameter int         N_READ_REGS = 9,
    parameter logic [7:0] RD_BASE     = 8'h21,
    parameter logic [7:0] CMD_ADDR    = 8'hF0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic [7:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    input  logic [7:0]       ad_in,
    output logic [7:0]       ad_out,
    output logic             ad_oe,
    output logic             ad_sel,
    output logic             cs_n,
    output logic             wr_n,
    output logic             rd_n,
    output logic             busy,
    output logic             wr_done,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic [IDX_W-1:0] rd_index
);

`ifdef RTC_XFER_CMD_EN
    localparam bit XFER_EN = 1'b1;
`else
    localparam bit XFER_EN = 1'b0;
`endif

    localparam int PER_W = $clog2(READ_PERIOD + 1);

    state_e           state_q, state_d;
    logic             phase_last, timer_load;
    logic             grant, grant_wr, grant_cmd;
    logic [7:0]       cur_addr_q, cur_data_q, pend_addr_q, pend_data_q, rd_data_q;
    logic             cur_wr_q, cur_cmd_q, pend_q, burst_q, cmd_pend_q;
    logic [IDX_W-1:0] cur_idx_q, burst_idx_q;
    logic [PER_W-1:0] per_cnt_q;
    logic             wrap, last_read_done;

    rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .last (phase_last)
    );

    assign wrap           = rd_en && (per_cnt_q == PER_W'(READ_PERIOD - 1));
    assign last_read_done = (state_q == ST_DONE) && !cur_wr_q
                            && (cur_idx_q == IDX_W'(N_READ_REGS - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        grant_wr   = 1'b0;
        grant_cmd  = 1'b0;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_req || pend_q) begin
                    grant    = 1'b1;
                    grant_wr = 1'b1;
                end else if (burst_q && rd_en) begin
                    grant     = 1'b1;
                    grant_cmd = XFER_EN && cmd_pend_q;
                end
                if (grant) begin
                    state_d    = ST_ADDR_SETUP;
                    timer_load = 1'b1;
                end
            end
            ST_ADDR_SETUP:  if (phase_last) begin state_d = ST_ADDR_STROBE; timer_load = 1'b1; end
            ST_ADDR_STROBE: if (phase_last) begin state_d = ST_ADDR_HOLD;   timer_load = 1'b1; end
            ST_ADDR_HOLD:   if (phase_last) begin state_d = ST_DATA_SETUP;  timer_load = 1'b1; end
            ST_DATA_SETUP:  if (phase_last) begin state_d = ST_DATA_STROBE; timer_load = 1'b1; end
            ST_DATA_STROBE: if (phase_last) begin state_d = ST_DATA_HOLD;   timer_load = 1'b1; end
            ST_DATA_HOLD:   if (phase_last) state_d = ST_DONE;
            ST_DONE:        state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            cur_addr_q  <= '0;
            cur_data_q  <= '0;
            cur_wr_q    <= 1'b0;
            cur_cmd_q   <= 1'b0;
            cur_idx_q   <= '0;
            burst_q     <= 1'b0;
            burst_idx_q <= '0;
            cmd_pend_q  <= 1'b0;
            rd_data_q   <= BUS_IDLE;
        end else begin
            per_cnt_q <= (!rd_en || wrap) ? '0 : per_cnt_q + PER_W'(1);

            // A request in IDLE is granted directly; otherwise it lands here, last one wins.
            if (wr_req && state_q != ST_IDLE) begin
                pend_q      <= 1'b1;
                pend_addr_q <= wr_addr;
                pend_data_q <= wr_data;
            end else if (grant_wr) begin
                pend_q <= 1'b0;
            end

            if (grant) begin
                if (grant_wr) begin
                    cur_addr_q <= wr_req ? wr_addr : pend_addr_q;
                    cur_data_q <= wr_req ? wr_data : pend_data_q;
                    cur_wr_q   <= 1'b1;
                    cur_cmd_q  <= 1'b0;
                end else if (grant_cmd) begin
                    cur_addr_q <= CMD_ADDR;
                    cur_data_q <= 8'h00;
                    cur_wr_q   <= 1'b1;
                    cur_cmd_q  <= 1'b1;
                    cmd_pend_q <= 1'b0;
                end else begin
                    cur_addr_q  <= RD_BASE + 8'(burst_idx_q);
                    cur_wr_q    <= 1'b0;
                    cur_cmd_q   <= 1'b0;
                    cur_idx_q   <= burst_idx_q;
                    burst_idx_q <= burst_idx_q + IDX_W'(1);
                end
            end

            // Wraps during an active burst are dropped rather than queued.
            if (!rd_en) begin
                burst_q <= 1'b0;
            end else if (wrap && !burst_q) begin
                burst_q     <= 1'b1;
                burst_idx_q <= '0;
                cmd_pend_q  <= XFER_EN;
            end else if (last_read_done) begin
                burst_q <= 1'b0;
            end

            if (state_q == ST_DATA_STROBE && phase_last && !cur_wr_q) rd_data_q <= ad_in;
        end
    end

    always_comb begin
        ad_out   = BUS_IDLE;
        ad_oe    = 1'b0;
        ad_sel   = 1'b0;
        cs_n     = 1'b1;
        wr_n     = 1'b1;
        rd_n     = 1'b1;
        wr_done  = 1'b0;
        rd_valid = 1'b0;
        case (state_q)
            ST_ADDR_SETUP, ST_ADDR_STROBE, ST_ADDR_HOLD: begin
                ad_oe  = 1'b1;
                ad_out = cur_addr_q;
                cs_n   = 1'b0;
                wr_n   = (state_q != ST_ADDR_STROBE);
            end
            ST_DATA_SETUP, ST_DATA_STROBE, ST_DATA_HOLD: begin
                ad_sel = 1'b1;
                cs_n   = 1'b0;
                if (cur_wr_q) begin
                    ad_oe  = 1'b1;
                    ad_out = cur_data_q;
                    wr_n   = (state_q != ST_DATA_STROBE);
                end else begin
                    rd_n   = (state_q != ST_DATA_STROBE);
                end
            end
            ST_DONE: begin
                wr_done  = cur_wr_q && !cur_cmd_q;
                rd_valid = !cur_wr_q;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign rd_data  = rd_data_q;
    assign rd_index = cur_idx_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - randomized scoreboard bench for rtc_bus_sequencer
module tb_rtc_bus_sequencer;

    localparam int         TP   = 2;
    localparam int         PER  = 50;
    localparam int         NREG = 3;
    localparam logic [7:0] BASE = 8'h21;
    localparam logic [7:0] CMDA = 8'hF0;
    localparam int         TX   = 6 * TP + 1;
`ifdef RTC_XFER_CMD_EN
    localparam bit XFER = 1'b1;
`else
    localparam bit XFER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, wr_req, rd_en;
    logic [7:0] wr_addr, wr_data, ad_in, ad_out, rd_data;
    logic       ad_oe, ad_sel, cs_n, wr_n, rd_n, busy, wr_done, rd_valid;
    logic [3:0] rd_index;

    always #5 clk = ~clk;

    rtc_bus_sequencer #(
        .T_PHASE(TP), .READ_PERIOD(PER), .N_READ_REGS(NREG), .RD_BASE(BASE), .CMD_ADDR(CMDA)
    ) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .ad_sel(ad_sel),
        .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .busy(busy), .wr_done(wr_done),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index)
    );

    logic [7:0] rtc_mem [256];
    logic [7:0] rtc_addr = 8'h00;
    assign ad_in = rtc_mem[rtc_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         is_wr;
        bit         is_cmd;
        logic [7:0] addr;
        logic [7:0] data;
        int         idx;
    } txn_t;
    txn_t exp_q[$];

    // Reference model: transactions as fixed-length slots of TX cycles.
    int         m_rem = 0, m_cnt = 0, m_idx = 0;
    bit         m_burst = 0, m_cmd = 0, m_pv = 0, m_cur_last = 0, m_rst_seen = 0;
    logic [7:0] m_pa, m_pd;
    bit         wrap, old_burst, last_rd_done;
    txn_t       t;

    always @(posedge clk) begin
        m_rst_seen = rst;
        if (rst) begin
            m_rem = 0; m_cnt = 0; m_idx = 0;
            m_burst = 0; m_cmd = 0; m_pv = 0; m_cur_last = 0;
            exp_q.delete();
        end else begin
            wrap         = rd_en && (m_cnt == PER - 1);
            old_burst    = m_burst;
            last_rd_done = 0;
            if (m_rem == 0) begin
                if (wr_req || m_pv) begin
                    t.is_wr = 1; t.is_cmd = 0; t.idx = 0;
                    t.addr  = wr_req ? wr_addr : m_pa;
                    t.data  = wr_req ? wr_data : m_pd;
                    m_pv = 0; m_cur_last = 0; m_rem = TX;
                    exp_q.push_back(t);
                end else if (m_burst && rd_en) begin
                    if (XFER && m_cmd) begin
                        t.is_wr = 1; t.is_cmd = 1; t.addr = CMDA; t.data = 8'h00; t.idx = 0;
                        m_cmd = 0; m_cur_last = 0;
                    end else begin
                        t.is_wr = 0; t.is_cmd = 0; t.idx = m_idx;
                        t.addr  = BASE + 8'(m_idx);
                        t.data  = rtc_mem[t.addr];
                        m_cur_last = (m_idx == NREG - 1);
                        m_idx++;
                    end
                    m_rem = TX;
                    exp_q.push_back(t);
                end
            end else begin
                if (wr_req) begin m_pv = 1; m_pa = wr_addr; m_pd = wr_data; end
                if (m_rem == 1 && m_cur_last) last_rd_done = 1;
                m_rem--;
            end
            if (!rd_en)                   m_burst = 0;
            else if (wrap && !old_burst)  begin m_burst = 1; m_idx = 0; m_cmd = XFER; end
            else if (last_rd_done)        m_burst = 0;
            m_cnt = (!rd_en || wrap) ? 0 : m_cnt + 1;
        end
    end

    // Monitor: rebuilds each transaction from the bus and pops the scoreboard at DONE.
    int         cs_cnt = 0, wa_cnt = 0, wd_cnt = 0, rd_cnt = 0, oe_cnt = 0;
    bit         seen_wr = 0, prev_cs_low = 0;
    logic [7:0] cap_addr = 0, cap_data = 0;
    txn_t       e;

    always @(negedge clk) begin
        if (m_rst_seen) begin
            chk("reset_idle", {ad_out, ad_oe, ad_sel, cs_n, wr_n, rd_n, busy, wr_done, rd_valid, rd_data, rd_index},
                {8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0});
            cs_cnt = 0; wa_cnt = 0; wd_cnt = 0; rd_cnt = 0; oe_cnt = 0; seen_wr = 0; prev_cs_low = 0;
        end else begin
            chk("busy", busy, m_rem != 0);
            if (!cs_n) begin
                cs_cnt++;
                if (!ad_sel && !wr_n) begin wa_cnt++; cap_addr = ad_out; rtc_addr = ad_out; end
                if (ad_sel && !wr_n)  begin wd_cnt++; cap_data = ad_out; seen_wr = 1; end
                if (ad_sel && !rd_n)  rd_cnt++;
                if (ad_sel && ad_oe)  oe_cnt++;
            end else if (prev_cs_low) begin
                chk("txn_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("kind_is_write", seen_wr, e.is_wr);
                    chk("addr", cap_addr, e.addr);
                    chk("cs_low_cycles", cs_cnt, 6 * TP);
                    chk("addr_strobe_cycles", wa_cnt, TP);
                    chk("wr_strobe_cycles", wd_cnt, e.is_wr ? TP : 0);
                    chk("rd_strobe_cycles", rd_cnt, e.is_wr ? 0 : TP);
                    chk("data_phase_oe_cycles", oe_cnt, e.is_wr ? 3 * TP : 0);
                    chk("wr_done", wr_done, e.is_wr && !e.is_cmd);
                    chk("rd_valid", rd_valid, !e.is_wr);
                    if (e.is_wr) begin
                        chk("wr_data", cap_data, e.data);
                    end else begin
                        chk("rd_data", rd_data, e.data);
                        chk("rd_index", rd_index, e.idx);
                    end
                end
                cs_cnt = 0; wa_cnt = 0; wd_cnt = 0; rd_cnt = 0; oe_cnt = 0; seen_wr = 0;
            end else begin
                chk("stray_pulse", {wr_done, rd_valid}, 2'b00);
            end
            prev_cs_low = !cs_n;
        end
    end

    task automatic wr_pulse(input logic [7:0] a, input logic [7:0] d);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rtc_mem[i] = 8'($urandom);
        rst = 1'b1; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00; rd_en = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(2);

        wr_pulse(8'h22, 8'h45);
        idle(20);

        wr_pulse(8'h22, 8'h45);
        idle(4);
        wr_pulse(8'h23, 8'h10);
        wr_pulse(8'h24, 8'h11);
        idle(40);

        wr_pulse(8'h30, 8'hAA);
        idle(1);
        wr_pulse(8'h31, 8'hBB);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(20);

        rd_en = 1'b1;
        idle(70);
        wr_pulse(8'h40, 8'h5A);
        idle(100);

        for (int c = 0; c < 4000; c++) begin
            wr_req  = ($urandom_range(0, 19) == 0);
            wr_addr = 8'($urandom);
            wr_data = 8'($urandom);
            if ($urandom_range(0, 299) == 0) rd_en = ~rd_en;
            rst     = ($urandom_range(0, 1499) == 0);
            @(negedge clk);
        end

        wr_req = 1'b0; rd_en = 1'b0; rst = 1'b0;
        idle(100);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
